ppu_line_tracker: RTL and testbench

Parametrised scanline and in-frame tracker for mapper cores, sitting between the sampled PPU bus and the mapper register file. It detects scanline boundaries from the three-identical-nametable-read signature and tracks in-frame state through a CPU-cycle watchdog. It also counts lines and fetches within a line and raises up to CH independent scanline-compare IRQs. Everything runs in the single `clk` domain and replaces per-mapper ad-hoc edge-clocked scanline logic.

---
 rtl/ppu_line_tracker_pkg.sv | 24 ++
 rtl/ppu_line_tracker_irq_ch.sv | 47 ++++
 rtl/ppu_line_tracker.sv | 140 ++++++++++++++
 tb/tb_ppu_line_tracker.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_line_tracker_pkg.sv
// Shared constants and small helpers for the PPU scanline tracker.
package ppu_trk_pkg;

  localparam int unsigned SPR_LO    = 128;
  localparam int unsigned SPR_HI    = 159;
  localparam int unsigned FETCH_MAX = 255;
  localparam logic [1:0]  EQ_SAT    = 2'd2;

  typedef logic [13:0] ppu_addr_t;
  typedef logic [7:0]  fetch_t;

  function automatic fetch_t fetch_inc(input fetch_t v);
    return (v == fetch_t'(FETCH_MAX)) ? v : v + fetch_t'(1);
  endfunction

  function automatic logic in_spr_window(input fetch_t v);
    return (v >= fetch_t'(SPR_LO)) && (v <= fetch_t'(SPR_HI));
  endfunction

  function automatic logic [1:0] eq_inc(input logic [1:0] v);
    return (v == EQ_SAT) ? EQ_SAT : v + 2'd1;
  endfunction

endpackage

// File: rtl/ppu_line_tracker_irq_ch.sv
// One scanline-compare channel: a sticky pending flag set when the new line matches.
module line_irq_ch
  import ppu_trk_pkg::*;
#(
  parameter int LINE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_stb_qual,
  input  logic [LINE_W-1:0] line_cnt_next,
  input  logic [LINE_W-1:0] cmp_val,
  input  logic              ack,
  input  logic              clear,
  output logic              pend
);

  logic pend_q;
  logic pend_d;
  logic hit;

  always_comb begin
    hit = line_stb_qual && (line_cnt_next == cmp_val) && (cmp_val != '0);
  end

  // Frame exit beats a new hit, and a new hit beats an acknowledge.
  always_comb begin
    pend_d = pend_q;
    if (clear) begin
      pend_d = 1'b0;
    end else if (hit) begin
      pend_d = 1'b1;
    end else if (ack) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/ppu_line_tracker.sv
// Scanline boundary detection (three identical nametable reads), in-frame
// watchdog on CPU M2 edges, line/fetch counters and per-channel compare IRQs.
module ppu_line_tracker
  import ppu_trk_pkg::*;
#(
  parameter int CH      = 2,
  parameter int LINE_W  = 8,
  parameter int TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 map_rst_n,
  input  logic                 ppu_oe_n,
  input  logic [13:0]          ppu_addr,
  input  logic                 m2_fall,
  input  logic                 bgr_on,
  input  logic [CH*LINE_W-1:0] cmp_val,
  input  logic [CH-1:0]        irq_en,
  input  logic [CH-1:0]        ack,
  output logic                 in_frame,
  output logic [LINE_W-1:0]    line_cnt,
  output logic [7:0]           fetch_cnt,
  output logic                 spr_fetch,
  output logic                 line_stb,
  output logic [CH-1:0]        irq_pend,
  output logic                 irq
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic              ppu_oe_n_q,  ppu_oe_n_d;
  ppu_addr_t         last_addr_q, last_addr_d;
  logic [1:0]        eq_cnt_q,    eq_cnt_d;
  logic [TMO_W-1:0]  tmo_q,       tmo_d;
  logic [LINE_W-1:0] line_cnt_q,  line_cnt_d;
  fetch_t            fetch_cnt_q, fetch_cnt_d;
  logic              line_stb_q,  line_stb_d;

  logic              rd_stb;
  logic              addr_match;
  logic              boundary;
  logic              in_frame_int;
  logic              line_stb_qual;
  logic [LINE_W-1:0] line_cnt_next;
  logic [CH-1:0]     pend_w;

  // Read strobe is the falling edge of /OE; the address is taken in the same cycle.
  always_comb begin
    rd_stb        = ppu_oe_n_q & ~ppu_oe_n;
    addr_match    = (ppu_addr == last_addr_q) & ppu_addr[13];
    boundary      = rd_stb & addr_match & (eq_cnt_q == 2'd1);
    in_frame_int  = (tmo_q != '0) & bgr_on;
    line_stb_qual = boundary & in_frame_int;
    line_cnt_next = line_cnt_q + LINE_W'(1);
  end

  always_comb begin
    ppu_oe_n_d  = ppu_oe_n;
    last_addr_d = last_addr_q;
    eq_cnt_d    = eq_cnt_q;
    if (rd_stb) begin
      last_addr_d = ppu_addr;
      eq_cnt_d    = addr_match ? eq_inc(eq_cnt_q) : 2'd0;
    end
  end

  // A read reloads the watchdog even if an M2 edge lands in the same cycle.
  always_comb begin
    tmo_d = tmo_q;
    if (rd_stb) begin
      tmo_d = TMO_W'(TIMEOUT);
    end else if (m2_fall && (tmo_q != '0)) begin
      tmo_d = tmo_q - TMO_W'(1);
    end
  end

  always_comb begin
    line_cnt_d = line_cnt_q;
    if (!in_frame_int) begin
      line_cnt_d = '0;
    end else if (boundary) begin
      line_cnt_d = line_cnt_next;
    end
  end

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (boundary) begin
      fetch_cnt_d = '0;
    end else if (rd_stb) begin
      fetch_cnt_d = fetch_inc(fetch_cnt_q);
    end
    line_stb_d = boundary;
  end

  always_ff @(posedge clk or negedge map_rst_n) begin
    if (!map_rst_n) begin
      ppu_oe_n_q  <= 1'b1;
      last_addr_q <= '0;
      eq_cnt_q    <= '0;
      tmo_q       <= '0;
      line_cnt_q  <= '0;
      fetch_cnt_q <= '0;
      line_stb_q  <= 1'b0;
    end else begin
      ppu_oe_n_q  <= ppu_oe_n_d;
      last_addr_q <= last_addr_d;
      eq_cnt_q    <= eq_cnt_d;
      tmo_q       <= tmo_d;
      line_cnt_q  <= line_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
      line_stb_q  <= line_stb_d;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    line_irq_ch #(
      .LINE_W (LINE_W)
    ) u_ch (
      .clk           (clk),
      .rst_n         (map_rst_n),
      .line_stb_qual (line_stb_qual),
      .line_cnt_next (line_cnt_next),
      .cmp_val       (cmp_val[i*LINE_W +: LINE_W]),
      .ack           (ack[i]),
      .clear         (~in_frame_int),
      .pend          (pend_w[i])
    );
  end

  always_comb begin
    in_frame  = in_frame_int;
    line_cnt  = line_cnt_q;
    fetch_cnt = fetch_cnt_q;
    spr_fetch = in_spr_window(fetch_cnt_q);
    line_stb  = line_stb_q;
    irq_pend  = pend_w;
    irq       = |(pend_w & irq_en);
  end

endmodule

// File: tb/tb_ppu_line_tracker.sv
// Bench for ppu_line_tracker: directed scenarios plus random traffic against a
// read-history / elapsed-M2 reference model.
module tb_ppu_line_tracker;

  localparam int CH      = 2;
  localparam int LINE_W  = 8;
  localparam int TIMEOUT = 4;

  logic                 clk = 1'b0;
  logic                 map_rst_n = 1'b0;
  logic                 ppu_oe_n = 1'b1;
  logic [13:0]          ppu_addr = '0;
  logic                 m2_fall = 1'b0;
  logic                 bgr_on = 1'b0;
  logic [CH*LINE_W-1:0] cmp_val = '0;
  logic [CH-1:0]        irq_en = '0;
  logic [CH-1:0]        ack = '0;
  logic                 in_frame;
  logic [LINE_W-1:0]    line_cnt;
  logic [7:0]           fetch_cnt;
  logic                 spr_fetch;
  logic                 line_stb;
  logic [CH-1:0]        irq_pend;
  logic                 irq;

  int n_total = 0;
  int n_pass  = 0;
  int dut_stb_count = 0;

  // Reference model state, kept in terms of read history and elapsed M2 edges.
  bit          m_prev_oe;
  logic [13:0] m_last;
  int          m_run;
  int          m_falls;
  bit          m_seen;
  int          m_line;
  int          m_fetch;
  bit          m_stb;
  bit [CH-1:0] m_pend;

  always #5 clk = ~clk;

  ppu_line_tracker #(
    .CH      (CH),
    .LINE_W  (LINE_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .map_rst_n (map_rst_n),
    .ppu_oe_n  (ppu_oe_n),
    .ppu_addr  (ppu_addr),
    .m2_fall   (m2_fall),
    .bgr_on    (bgr_on),
    .cmp_val   (cmp_val),
    .irq_en    (irq_en),
    .ack       (ack),
    .in_frame  (in_frame),
    .line_cnt  (line_cnt),
    .fetch_cnt (fetch_cnt),
    .spr_fetch (spr_fetch),
    .line_stb  (line_stb),
    .irq_pend  (irq_pend),
    .irq       (irq)
  );

  function automatic bit m_in_frame();
    return m_seen && (m_falls < TIMEOUT) && bgr_on;
  endfunction

  task automatic m_reset();
    m_prev_oe = 1'b1;
    m_last    = '0;
    m_run     = 0;
    m_falls   = 0;
    m_seen    = 1'b0;
    m_line    = 0;
    m_fetch   = 0;
    m_stb     = 1'b0;
    m_pend    = '0;
  endtask

  // Advance model and DUT by one clock using the inputs currently driven.
  task automatic tick();
    bit rd, bnd, inf;
    int nl, cv;
    rd  = m_prev_oe && !ppu_oe_n;
    inf = m_in_frame();
    bnd = 1'b0;
    if (rd) begin
      m_run  = (m_run > 0 && ppu_addr == m_last) ? m_run + 1 : 1;
      m_last = ppu_addr;
      bnd    = ppu_addr[13] && (m_run == 3);
    end
    nl = (m_line + 1) % (1 << LINE_W);
    for (int i = 0; i < CH; i++) begin
      cv = int'(cmp_val[i*LINE_W +: LINE_W]);
      if (!inf) m_pend[i] = 1'b0;
      else if (bnd && nl == cv && cv != 0) m_pend[i] = 1'b1;
      else if (ack[i]) m_pend[i] = 1'b0;
    end
    m_line  = !inf ? 0 : (bnd ? nl : m_line);
    m_fetch = bnd ? 0 : (rd ? ((m_fetch < 255) ? m_fetch + 1 : 255) : m_fetch);
    m_stb   = bnd;
    if (rd) begin
      m_seen  = 1'b1;
      m_falls = 0;
    end else if (m2_fall && m_falls < TIMEOUT) begin
      m_falls++;
    end
    m_prev_oe = ppu_oe_n;
    @(posedge clk);
    #1;
    if (line_stb) dut_stb_count++;
  endtask

  task automatic rd(input logic [13:0] a, input logic [CH-1:0] ak);
    ppu_oe_n = 1'b0;
    ppu_addr = a;
    ack      = ak;
    tick();
    ack      = '0;
    ppu_oe_n = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    map_rst_n = 1'b0;
    ppu_oe_n  = 1'b1;
    m2_fall   = 1'b0;
    ack       = '0;
    m_reset();
    @(negedge clk);
    map_rst_n = 1'b1;
    dut_stb_count = 0;
  endtask

  task automatic test_reset();
    m_reset();
    #3;
    n_total++;
    if ({in_frame, line_cnt, fetch_cnt, spr_fetch, line_stb, irq_pend, irq} !== '0)
      $display("FAIL reset_outputs: got %0h expected 0",
               {in_frame, line_cnt, fetch_cnt, spr_fetch, line_stb, irq_pend, irq});
    else n_pass++;
    @(negedge clk);
    map_rst_n = 1'b1;
  endtask

  task automatic test_boundary();
    do_reset();
    bgr_on = 1'b1; cmp_val = '0; irq_en = '0;
    for (int k = 0; k < 3; k++) rd(14'h2000, '0);
    n_total++;
    if (dut_stb_count !== 1) $display("FAIL bnd_third_read: stb_count %0d expected 1", dut_stb_count);
    else n_pass++;
    rd(14'h2000, '0);
    n_total++;
    if (dut_stb_count !== 1) $display("FAIL bnd_fourth_read: stb_count %0d expected 1", dut_stb_count);
    else n_pass++;
    n_total++;
    if (line_cnt !== 8'd1) $display("FAIL bnd_line_cnt: got %0d expected 1", line_cnt);
    else n_pass++;
    n_total++;
    if (fetch_cnt !== 8'd1) $display("FAIL bnd_fetch_cnt: got %0d expected 1", fetch_cnt);
    else n_pass++;
  endtask

  task automatic test_non_nametable();
    do_reset();
    bgr_on = 1'b1;
    for (int k = 0; k < 3; k++) rd(14'h1000, '0);
    n_total++;
    if (dut_stb_count !== 0) $display("FAIL nt_no_stb: stb_count %0d expected 0", dut_stb_count);
    else n_pass++;
    n_total++;
    if (fetch_cnt !== 8'd3) $display("FAIL nt_fetch_cnt: got %0d expected 3", fetch_cnt);
    else n_pass++;
  endtask

  task automatic test_compare_irq();
    do_reset();
    bgr_on = 1'b1; cmp_val = {8'd5, 8'd3}; irq_en = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      for (int r = 0; r < 3; r++) rd(14'h2000 + 14'(k), '0);
      n_total++;
      if (line_cnt !== 8'(k)) $display("FAIL cmp_line_%0d: got %0d expected %0d", k, line_cnt, k);
      else n_pass++;
      n_total++;
      if (irq_pend !== {k >= 5, k >= 3})
        $display("FAIL cmp_pend_%0d: got %b expected %b", k, irq_pend, {k >= 5, k >= 3});
      else n_pass++;
      n_total++;
      if (irq !== (k >= 3)) $display("FAIL cmp_irq_%0d: got %b expected %b", k, irq, k >= 3);
      else n_pass++;
    end
    ack = 2'b01;
    tick();
    ack = '0;
    n_total++;
    if (irq_pend !== 2'b10 || irq !== 1'b0)
      $display("FAIL cmp_ack_masked: pend %b irq %b expected pend 10 irq 0", irq_pend, irq);
    else n_pass++;
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      rd(14'h2000 + 14'(k), '0);
      rd(14'h2000 + 14'(k), '0);
      rd(14'h2000 + 14'(k), (k == 3) ? 2'b01 : 2'b00);
    end
    n_total++;
    if (irq_pend[0] !== 1'b1) $display("FAIL cmp_set_beats_ack: got %b expected 1", irq_pend[0]);
    else n_pass++;
  endtask

  task automatic test_watchdog();
    do_reset();
    bgr_on = 1'b1; cmp_val = {8'd5, 8'd3}; irq_en = 2'b01;
    for (int k = 1; k <= 3; k++)
      for (int r = 0; r < 3; r++) rd(14'h2000 + 14'(k), '0);
    for (int p = 1; p <= TIMEOUT; p++) begin
      m2_fall = 1'b1;
      tick();
      m2_fall = 1'b0;
      n_total++;
      if (in_frame !== (p < TIMEOUT))
        $display("FAIL wd_pulse_%0d: in_frame %b expected %b", p, in_frame, p < TIMEOUT);
      else n_pass++;
      tick();
    end
    n_total++;
    if (line_cnt !== '0 || irq_pend !== '0)
      $display("FAIL wd_exit_clear: line %0d pend %b expected 0 and 00", line_cnt, irq_pend);
    else n_pass++;
    rd(14'h2100, '0);
    for (int p = 1; p < TIMEOUT; p++) begin
      m2_fall = 1'b1; tick(); m2_fall = 1'b0; tick();
    end
    rd(14'h2101, '0);
    m2_fall = 1'b1; tick(); m2_fall = 1'b0;
    n_total++;
    if (in_frame !== 1'b1) $display("FAIL wd_reload: in_frame %b expected 1", in_frame);
    else n_pass++;
    bgr_on = 1'b0;
    #1;
    n_total++;
    if (in_frame !== 1'b0) $display("FAIL wd_bgr_off: in_frame %b expected 0", in_frame);
    else n_pass++;
    bgr_on = 1'b1;
  endtask

  task automatic test_sprite_sat();
    int exp_f;
    do_reset();
    bgr_on = 1'b1;
    for (int r = 0; r < 3; r++) rd(14'h2000, '0);
    for (int n = 1; n <= 300; n++) begin
      rd(14'(n), '0);
      exp_f = (n > 255) ? 255 : n;
      n_total++;
      if (fetch_cnt !== 8'(exp_f)) $display("FAIL spr_fetch_cnt_%0d: got %0d expected %0d", n, fetch_cnt, exp_f);
      else n_pass++;
      n_total++;
      if (spr_fetch !== (exp_f >= 128 && exp_f <= 159))
        $display("FAIL spr_window_%0d: got %b expected %b", n, spr_fetch, exp_f >= 128 && exp_f <= 159);
      else n_pass++;
    end
  endtask

  task automatic test_cmp_zero_wrap();
    do_reset();
    bgr_on = 1'b1; cmp_val = '0; irq_en = 2'b11;
    for (int k = 1; k <= 256; k++) begin
      for (int r = 0; r < 3; r++) rd((k % 2) ? 14'h2000 : 14'h2400, '0);
      n_total++;
      if (irq_pend !== '0) $display("FAIL zero_no_pend_%0d: got %b expected 00", k, irq_pend);
      else n_pass++;
      n_total++;
      if (line_cnt !== 8'(k % 256)) $display("FAIL wrap_line_%0d: got %0d expected %0d", k, line_cnt, k % 256);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bgr_on = 1'b1; cmp_val = {8'd2, 8'd1}; irq_en = 2'b11;
    rd(14'h2000, '0);
    rd(14'h2000, '0);
    ppu_oe_n = 1'b0;
    ppu_addr = 14'h2000;
    tick();
    n_total++;
    if (line_stb !== 1'b1 || irq_pend !== 2'b01)
      $display("FAIL mid_pre_reset: stb %b pend %b expected 1 and 01", line_stb, irq_pend);
    else n_pass++;
    #2;
    map_rst_n = 1'b0;
    ppu_oe_n  = 1'b1;
    m_reset();
    #1;
    n_total++;
    if ({in_frame, line_cnt, fetch_cnt, spr_fetch, line_stb, irq_pend, irq} !== '0)
      $display("FAIL mid_reset_outputs: got %0h expected 0",
               {in_frame, line_cnt, fetch_cnt, spr_fetch, line_stb, irq_pend, irq});
    else n_pass++;
    @(negedge clk);
    map_rst_n = 1'b1;
    dut_stb_count = 0;
    rd(14'h2000, '0);
    rd(14'h2000, '0);
    n_total++;
    if (dut_stb_count !== 0) $display("FAIL mid_two_reads: stb_count %0d expected 0", dut_stb_count);
    else n_pass++;
    rd(14'h2000, '0);
    n_total++;
    if (dut_stb_count !== 1 || line_cnt !== 8'd1)
      $display("FAIL mid_third_read: stb_count %0d line %0d expected 1 and 1", dut_stb_count, line_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [13:0] addrs [4];
    addrs[0] = 14'h2000; addrs[1] = 14'h2000; addrs[2] = 14'h23C0; addrs[3] = 14'h1000;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        for (int i = 0; i < CH; i++) cmp_val[i*LINE_W +: LINE_W] = 8'($urandom_range(0, 6));
        irq_en = CH'($urandom_range(0, (1 << CH) - 1));
      end
      ppu_oe_n = 1'($urandom_range(0, 1));
      ppu_addr = addrs[$urandom_range(0, 3)];
      m2_fall  = ($urandom_range(0, 3) == 0);
      bgr_on   = ($urandom_range(0, 63) != 0);
      for (int i = 0; i < CH; i++) ack[i] = ($urandom_range(0, 7) == 0);
      tick();
      n_total++;
      if (in_frame !== m_in_frame()) $display("FAIL rnd_in_frame c%0d: got %b expected %b", c, in_frame, m_in_frame());
      else n_pass++;
      n_total++;
      if (line_cnt !== LINE_W'(m_line)) $display("FAIL rnd_line_cnt c%0d: got %0d expected %0d", c, line_cnt, m_line);
      else n_pass++;
      n_total++;
      if (fetch_cnt !== 8'(m_fetch)) $display("FAIL rnd_fetch_cnt c%0d: got %0d expected %0d", c, fetch_cnt, m_fetch);
      else n_pass++;
      n_total++;
      if (spr_fetch !== (m_fetch >= 128 && m_fetch <= 159))
        $display("FAIL rnd_spr_fetch c%0d: got %b expected %b", c, spr_fetch, m_fetch >= 128 && m_fetch <= 159);
      else n_pass++;
      n_total++;
      if (line_stb !== m_stb) $display("FAIL rnd_line_stb c%0d: got %b expected %b", c, line_stb, m_stb);
      else n_pass++;
      n_total++;
      if (irq_pend !== m_pend) $display("FAIL rnd_irq_pend c%0d: got %b expected %b", c, irq_pend, m_pend);
      else n_pass++;
      n_total++;
      if (irq !== |(m_pend & irq_en)) $display("FAIL rnd_irq c%0d: got %b expected %b", c, irq, |(m_pend & irq_en));
      else n_pass++;
    end
    ack = '0; m2_fall = 1'b0; ppu_oe_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_boundary();
    test_non_nametable();
    test_compare_irq();
    test_watchdog();
    test_sprite_sat();
    test_cmp_zero_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
